// File: rtl/pwm_led_array.sv
// Multi-channel PWM LED driver with steady/blink/fade/off modes.
// Level and mode changes are double-buffered and only take effect at a frame boundary.
module pwm_led_array #(
  parameter int unsigned CHANNELS     = 3,
  parameter int unsigned PWM_BITS     = 8,
  parameter int unsigned BLINK_PERIOD = 27000000,
  parameter int unsigned FADE_FRAMES  = 1024,
  parameter logic        VALUE_ON     = 1'b0,
  parameter logic        VALUE_OFF    = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CHANNELS*PWM_BITS-1:0] level_in,
  input  logic [1:0]                   mode_in,
  input  logic                         update,
  output logic                         pending,
  output logic                         frame_start,
  output logic [CHANNELS-1:0]          led
);

  localparam int unsigned N  = PWM_BITS;
  localparam int unsigned BW = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
  localparam int unsigned FW = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;

  localparam logic [N-1:0]  LastCycle = N'((1 << N) - 2);
  localparam logic [BW-1:0] BlinkLast = BW'(BLINK_PERIOD - 1);
  localparam logic [BW-1:0] BlinkHalf = BW'(BLINK_PERIOD / 2);
  localparam logic [FW-1:0] FadeLast  = FW'(FADE_FRAMES - 1);
  localparam logic [N:0]    EnvTop    = {1'b1, {N{1'b0}}};

  typedef enum logic [1:0] {ModeSteady, ModeBlink, ModeFade, ModeOff} mode_e;

  logic [N-1:0]            cycle_q, cycle_d;
  logic [BW-1:0]           blink_q, blink_d;
  logic [FW-1:0]           frame_q, frame_d;
  logic [N:0]              env_q, env_d;
  logic                    env_up_q, env_up_d;
  logic [CHANNELS*N-1:0]   lvl_q, lvl_d, shadow_lvl_q, shadow_lvl_d;
  mode_e                   mode_q, mode_d, shadow_mode_q, shadow_mode_d;
  logic                    pending_q, pending_d;
  logic [CHANNELS-1:0]     led_q, led_d;
  logic                    frame_start_q, frame_start_d;

  logic                    boundary, apply;
  logic [CHANNELS*N-1:0]   new_lvl;
  mode_e                   new_mode;
  logic [2*N:0]            prod [CHANNELS];
  logic [N-1:0]            eff  [CHANNELS];

  always_comb begin
    boundary      = (cycle_q == LastCycle);
    cycle_d       = boundary ? '0 : cycle_q + 1'b1;
    blink_d       = (blink_q == BlinkLast) ? '0 : blink_q + 1'b1;

    shadow_lvl_d  = update ? level_in : shadow_lvl_q;
    shadow_mode_d = update ? mode_e'(mode_in) : shadow_mode_q;
    // An update on the boundary clock bypasses the shadow and applies immediately.
    apply         = boundary && (pending_q || update);
    new_lvl       = shadow_lvl_d;
    new_mode      = shadow_mode_d;

    pending_d = pending_q;
    if (apply) begin
      pending_d = 1'b0;
    end else if (update) begin
      pending_d = 1'b1;
    end

    frame_d  = frame_q;
    env_d    = env_q;
    env_up_d = env_up_q;
    if (boundary) begin
      if (frame_q == FadeLast) begin
        frame_d = '0;
        // Triangle envelope: each endpoint is held for one step, then direction flips.
        if (env_up_q) begin
          if (env_q == EnvTop) begin
            env_d    = env_q - 1'b1;
            env_up_d = 1'b0;
          end else begin
            env_d = env_q + 1'b1;
          end
        end else begin
          if (env_q == '0) begin
            env_d    = env_q + 1'b1;
            env_up_d = 1'b1;
          end else begin
            env_d = env_q - 1'b1;
          end
        end
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end

    lvl_d  = apply ? new_lvl : lvl_q;
    mode_d = apply ? new_mode : mode_q;
    if (apply && (new_mode != mode_q)) begin
      blink_d  = '0;
      frame_d  = '0;
      env_d    = '0;
      env_up_d = 1'b1;
    end
  end

  always_comb begin
    prod = '{default: '0};
    eff  = '{default: '0};
    led_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      prod[i] = (2*N+1)'(lvl_q[i*N +: N]) * (2*N+1)'(env_q);
      unique case (mode_q)
        ModeSteady: eff[i] = lvl_q[i*N +: N];
        ModeBlink:  eff[i] = (blink_q < BlinkHalf) ? lvl_q[i*N +: N] : '0;
        ModeFade:   eff[i] = N'(prod[i] >> N);
        ModeOff:    eff[i] = '0;
        default:    eff[i] = '0;
      endcase
      led_d[i] = (cycle_q < eff[i]) ? VALUE_ON : VALUE_OFF;
    end
    frame_start_d = (cycle_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q       <= '0;
      blink_q       <= '0;
      frame_q       <= '0;
      env_q         <= '0;
      env_up_q      <= 1'b1;
      lvl_q         <= '0;
      mode_q        <= ModeSteady;
      shadow_lvl_q  <= '0;
      shadow_mode_q <= ModeSteady;
      pending_q     <= 1'b0;
      led_q         <= {CHANNELS{VALUE_OFF}};
      frame_start_q <= 1'b0;
    end else begin
      cycle_q       <= cycle_d;
      blink_q       <= blink_d;
      frame_q       <= frame_d;
      env_q         <= env_d;
      env_up_q      <= env_up_d;
      lvl_q         <= lvl_d;
      mode_q        <= mode_d;
      shadow_lvl_q  <= shadow_lvl_d;
      shadow_mode_q <= shadow_mode_d;
      pending_q     <= pending_d;
      led_q         <= led_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pending     = pending_q;
  assign frame_start = frame_start_q;
  assign led         = led_q;

endmodule
